button_debounce: RTL and testbench
==================================

Name: button_debounce

Overview:
Parametrised multi-channel push-button conditioner. It replaces the plain synchroniser-plus-edge-detect with:
- a configurable synchroniser depth,
- a counter-based stability filter,
- selectable input polarity,
- separate one-cycle press and release pulses.

It sits between board button pins and user logic (menus, mode counters, LED demos). Each channel is independent.

Parameters:
CH, 4, number of independent button channels
SYNC_STAGES, 2, synchroniser flops per channel (min 2)
DEBOUNCE_CYCLES, 1000000, consecutive stable clk cycles needed to accept a new level (20 ms at 50 MHz; min 1)
ACTIVE_LOW, 1, 1 = pin reads 0 when pressed; 0 = pin reads 1 when pressed
CNT_W, $clog2(DEBOUNCE_CYCLES+1), stability counter width (derived; do not override)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
button  in  CH  raw asynchronous button pins
btn_level  out  CH  debounced pressed state (1 = pressed)
btn_press  out  CH  one-cycle pulse on accepted press
btn_release  out  CH  one-cycle pulse on accepted release

Behaviour:
- Reset values:
  - all synchroniser flops load the released pin level (ACTIVE_LOW ? 1 : 0);
  - btn_level, btn_press, btn_release = 0;
  - counters = 0.
- Reset is asserted asynchronously. Deassertion is used directly (no reset synchroniser in this block).
- Per channel: p = sync output XOR ACTIVE_LOW, giving a normalised pressed level.
- Each channel runs a two-state FSM:
  - RELEASED: btn_level = 0.
  - PRESSED: btn_level = 1.
- Counter update, each clk:
  - if p == btn_level: cnt <= 0;
  - else if cnt == DEBOUNCE_CYCLES-1: flip state, cnt <= 0, and pulse btn_press (RELEASED->PRESSED) or btn_release (PRESSED->RELEASED) for exactly one cycle;
  - else: cnt <= cnt+1.
- Pulses are registered and change on the same edge as btn_level.
- Any bounce (p returns to btn_level) before the count completes restarts the count from 0. No pulse is produced.
- Latency: a clean input change stable before edge e0 gives outputs updated after edge e0+SYNC_STAGES+DEBOUNCE_CYCLES-1, i.e. SYNC_STAGES+DEBOUNCE_CYCLES cycles.
- btn_press and btn_release of one channel are never high together. At most one pulse per channel per accepted transition.
- Minimum spacing between consecutive pulses on one channel is DEBOUNCE_CYCLES cycles.
- Channels never interact. Simultaneous transitions on several channels each produce their own pulse in the same cycle.
- Reset mid-count or while PRESSED: state returns to RELEASED with no release pulse. A held button after reset produces a fresh press pulse after the full latency.
- Counter saturation cannot occur: cnt never exceeds DEBOUNCE_CYCLES-1.

Optional Feature:
Macro: BUTTON_DEBOUNCE_REPEAT_EN.

When defined:
- Extra parameters:
  - REPEAT_DELAY (default 25000000): cycles after the press pulse before the first repeat.
  - REPEAT_PERIOD (default 5000000): cycles between later repeats.
- Extra output btn_repeat [CH]: one-cycle pulses while PRESSED.
  - First pulse REPEAT_DELAY cycles after btn_press.
  - Then one every REPEAT_PERIOD cycles.
- A separate repeat counter is cleared on entering RELEASED and on reset.
- A release acceptance in the same cycle as a due repeat suppresses the repeat.

When undefined: no btn_repeat port and no repeat counter logic.

Decomposition:
- Package button_pkg holds:
  - the state encoding (BTN_RELEASED=0, BTN_PRESSED=1) as a typedef;
  - default constants DEFAULT_DEBOUNCE_CYCLES and DEFAULT_SYNC_STAGES.
- One sub-module, button_debounce_ch (one channel: synchroniser, counter, FSM, optional repeat), instantiated CH times in a generate loop.

Test Plan (CH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1; repeat: DELAY=8, PERIOD=3):
- Reset: rst_n=0 with button=2'b11, release reset -> all outputs 0 and no pulses for 20 cycles.
- Clean press: button[0] 1->0 and held -> btn_press[0] high exactly 1 cycle, 6 cycles after the change; btn_level[0]=1 from then on; channel 1 unaffected.
- Bounce: button[0] toggles low 3 cycles / high 1 cycle, repeated 5 times, then holds low -> exactly one btn_press[0], 6 cycles after the final low edge.
- Release plus both channels: both pins 0->1 in the same cycle after a press -> btn_release[1:0]=2'b11 in a single cycle, btn_level=0; btn_press stays 0.
- Reset mid-hold: pressed channel, pulse rst_n low for 1 cycle -> btn_level drops asynchronously with no release pulse; new btn_press 6 cycles after reset deassertion.
- Repeat (macro defined): hold for 30 cycles -> btn_repeat pulses at 8, 11, 14, … cycles after btn_press; none after release is accepted.

Source files
------------

// File: rtl/button_pkg.sv
// Shared state encoding and default constants for the button_debounce slice.
package button_pkg;

  typedef enum logic {
    BTN_RELEASED = 1'b0,
    BTN_PRESSED  = 1'b1
  } btn_state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
  localparam int DEFAULT_SYNC_STAGES     = 2;

endpackage

// File: rtl/button_debounce_ch.sv
// One button channel: synchroniser, stability counter, press/release FSM.
// Auto-repeat logic is built only when BUTTON_DEBOUNCE_REPEAT_EN is defined.
//
// state        | meaning
// BTN_RELEASED | debounced level 0, waiting for a stable press
// BTN_PRESSED  | debounced level 1, waiting for a stable release
module button_debounce_ch import button_pkg::*; #(
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic level,
  output logic press_pulse,
  output logic release_pulse
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  ,
  output logic repeat_pulse
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CNT_W-1:0]       cnt;
  btn_state_t             state;
  logic                   p;
  logic                   accept;

  assign p      = sync[SYNC_STAGES-1] ^ ACTIVE_LOW;
  assign accept = (p != state) && (cnt == CNT_LAST);
  assign level  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync          <= {SYNC_STAGES{ACTIVE_LOW}};
      state         <= BTN_RELEASED;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync          <= {sync[SYNC_STAGES-2:0], button};
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (p == state) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt <= '0;
        if (state == BTN_RELEASED) begin
          state       <= BTN_PRESSED;
          press_pulse <= 1'b1;
        end else begin
          state         <= BTN_RELEASED;
          release_pulse <= 1'b1;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rcnt;
  logic             rfirst;

  // Any acceptance (press or release) restarts the schedule; a release
  // acceptance therefore also swallows a repeat that falls due on that edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt         <= '0;
      rfirst       <= 1'b1;
      repeat_pulse <= 1'b0;
    end else begin
      repeat_pulse <= 1'b0;
      if (state == BTN_RELEASED || accept) begin
        rcnt   <= '0;
        rfirst <= 1'b1;
      end else if (rcnt == (rfirst ? DELAY_LAST : PERIOD_LAST)) begin
        rcnt         <= '0;
        rfirst       <= 1'b0;
        repeat_pulse <= 1'b1;
      end else begin
        rcnt <= rcnt + REP_W'(1);
      end
    end
  end
`endif

endmodule

// File: rtl/button_debounce.sv
// Multi-channel push-button conditioner; one button_debounce_ch per pin.
// Define BUTTON_DEBOUNCE_REPEAT_EN to add the btn_repeat auto-repeat output.
module button_debounce import button_pkg::*; #(
  parameter int CH              = 4,
  parameter int SYNC_STAGES     = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  ,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] button,
  output logic [CH-1:0] btn_level,
  output logic [CH-1:0] btn_press,
  output logic [CH-1:0] btn_release
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  ,
  output logic [CH-1:0] btn_repeat
`endif
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    button_debounce_ch #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW),
      .CNT_W           (CNT_W)
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
      ,
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk           (clk),
      .rst_n         (rst_n),
      .button        (button[i]),
      .level         (btn_level[i]),
      .press_pulse   (btn_press[i]),
      .release_pulse (btn_release[i])
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
      ,
      .repeat_pulse  (btn_repeat[i])
`endif
    );
  end

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce (CH=2, SYNC=2, DEBOUNCE=4, active-low).
module tb_button_debounce;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] button;
  logic [1:0] btn_level, btn_press, btn_release;
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  logic [1:0] btn_repeat;
`endif

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  button_debounce #(
    .CH              (2),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4),
    .ACTIVE_LOW      (1'b1)
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    ,
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (3)
`endif
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .button      (button),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
    ,
    .btn_repeat  (btn_repeat)
`endif
  );

  // {level, press, release}
  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

`ifdef BUTTON_DEBOUNCE_REPEAT_EN
  task automatic chk_rep(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  function automatic logic [5:0] outs();
    return {btn_level, btn_press, btn_release};
  endfunction

  initial begin
    button = 2'b11;
    rst_n  = 1'b0;
    #2;
    chk("in_reset", outs(), 6'b00_00_00);
    steps(3);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      chk("idle_after_reset", outs(), 6'b00_00_00);
    end

    // clean press on channel 0
    button = 2'b10;
    steps(5);
    chk("press_early", outs(), 6'b00_00_00);
    step();
    chk("press_pulse", outs(), 6'b01_01_00);
    step();
    chk("press_hold", outs(), 6'b01_00_00);

    // clean release on channel 0
    button = 2'b11;
    steps(5);
    chk("release_early", outs(), 6'b01_00_00);
    step();
    chk("release_pulse", outs(), 6'b00_00_01);
    step();
    chk("release_after", outs(), 6'b00_00_00);

    // bounce: low 3 / high 1, five times, then hold low
    for (int r = 0; r < 5; r++) begin
      button = 2'b10;
      for (int k = 0; k < 3; k++) begin
        step();
        chk("bounce_quiet", outs(), 6'b00_00_00);
      end
      button = 2'b11;
      step();
      chk("bounce_quiet", outs(), 6'b00_00_00);
    end
    button = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("bounce_settle", outs(), 6'b00_00_00);
    end
    step();
    chk("bounce_press", outs(), 6'b01_01_00);
    step();
    chk("bounce_hold", outs(), 6'b01_00_00);

    // press channel 1, then release both together
    button = 2'b00;
    steps(6);
    chk("ch1_press", outs(), 6'b11_10_00);
    step();
    button = 2'b11;
    steps(5);
    chk("both_release_early", outs(), 6'b11_00_00);
    step();
    chk("both_release", outs(), 6'b00_00_11);
    step();
    chk("both_release_after", outs(), 6'b00_00_00);

    // press channel 0, then reset mid-hold
    button = 2'b10;
    steps(6);
    chk("pre_reset_press", outs(), 6'b01_01_00);
    steps(3);
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), 6'b00_00_00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("post_reset_wait", outs(), 6'b00_00_00);
    end
    step();
    chk("post_reset_press", outs(), 6'b01_01_00);

    // hold, then release so acceptance lands on a due repeat (k=26)
    for (int k = 1; k <= 34; k++) begin
      logic [5:0] exp;
      exp = {(k < 26) ? 2'b01 : 2'b00, 2'b00, (k == 26) ? 2'b01 : 2'b00};
      step();
      chk("hold_release", outs(), exp);
`ifdef BUTTON_DEBOUNCE_REPEAT_EN
      chk_rep("repeat", btn_repeat,
              (k < 26 && k >= 8 && ((k - 8) % 3) == 0) ? 2'b01 : 2'b00);
`endif
      if (k == 20) button = 2'b11;
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
